shared_mem_arbiter: RTL and testbench

Round-robin initiator that lets `N_CORES` single-cycle cores share one word-addressed shared data memory. Each core raises a request with address, write-enable and write data and holds it until acknowledged. The arbiter serializes the requests onto the shared memory's port (`mem_read`, `mem_write`, `address`, `data_in`, `sharedAccess`) and returns read data with a one-cycle acknowledge. It sits between the core array and the shared memory in the manycore top level.

---
 rtl/shared_arb_pkg.sv | 22 ++
 rtl/rr_picker.sv | 34 +++
 rtl/shared_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_arb_pkg.sv
// Shared types and constants for the shared-memory round-robin arbiter.
package shared_arb_pkg;

  // Arbiter FSM: idle/grant cycle, then a single memory access cycle.
  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } arb_state_e;

  // Width of the shared-memory address and data buses.
  localparam int unsigned DataW = 32;

  // Per-core grant statistics counters (optional feature).
  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] CntMax = 16'hFFFF;

  // Index width for a core count; never below 1 bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request scanning upward
// from ptr, wrapping modulo N_CORES.
module rr_picker
  import shared_arb_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned IDX_W   = idx_w(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int unsigned cand;

  // Scan offsets 0..N_CORES-1 from ptr; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_CORES) begin
        cand = cand - N_CORES;
      end
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serialising single-cycle core requests onto one shared
// data memory port. Optional per-core grant counters under SHARED_ARB_STATS_EN.
module shared_mem_arbiter
  import shared_arb_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned ADDR_W  = DataW
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_CORES-1:0]        core_req,
  input  logic [N_CORES-1:0]        core_we,
  input  logic [N_CORES*ADDR_W-1:0] core_addr,
  input  logic [N_CORES*ADDR_W-1:0] core_wdata,
  output logic [N_CORES-1:0]        core_ack,
  output logic [ADDR_W-1:0]         core_rdata,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic                      sharedAccess,
  output logic [ADDR_W-1:0]         address,
  output logic [ADDR_W-1:0]         data_in,
  input  logic [ADDR_W-1:0]         data_out
`ifdef SHARED_ARB_STATS_EN
  ,
  output logic [N_CORES*CntW-1:0]   grant_cnt
`endif
);

  localparam int unsigned IdxW = idx_w(N_CORES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_CORES - 1);

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    wdata_q, wdata_d;
  logic [N_CORES-1:0]   ack_q, ack_d;
  logic [ADDR_W-1:0]    rdata_q, rdata_d;

  logic [N_CORES-1:0]   eligible;
  logic                 pick_valid;
  logic [IdxW-1:0]      pick_idx;

  // The core being acked still holds its request this cycle; hide it so it
  // is not granted twice.
  assign eligible = core_req & ~ack_q;

  rr_picker #(
    .N_CORES (N_CORES),
    .IDX_W   (IdxW)
  ) u_rr_picker (
    .req   (eligible),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state: latch the picked request in idle, complete it in access.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          we_d    = core_we[pick_idx];
          addr_d  = core_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_d = core_wdata[int'(pick_idx)*ADDR_W +: ADDR_W];
          state_d = StAccess;
        end
      end
      StAccess: begin
        ack_d[idx_q] = 1'b1;
        if (!we_q) begin
          rdata_d = data_out;
        end
        ptr_d   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from the state register so an async reset
  // removes them immediately.
  always_comb begin
    sharedAccess = (state_q == StAccess);
    mem_read     = sharedAccess & ~we_q;
    mem_write    = sharedAccess & we_q;
    address      = addr_q;
    data_in      = wdata_q;
    core_ack     = ack_q;
    core_rdata   = rdata_q;
  end

`ifdef SHARED_ARB_STATS_EN
  logic [CntW-1:0] cnt_q [N_CORES];

  // Saturating grant counters; bump on the edge that raises core_ack[idx].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < N_CORES; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (state_q == StAccess && cnt_q[idx_q] != CntMax) begin
      cnt_q[idx_q] <= cnt_q[idx_q] + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_cnt_out
    assign grant_cnt[g*CntW +: CntW] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a small word-addressed memory
// model (word i initialised to 100+i). Define SHARED_ARB_STATS_EN to also
// exercise the grant counters.
module tb_shared_mem_arbiter;

  localparam int unsigned NC = 4;
  localparam int unsigned AW = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NC-1:0]     core_req;
  logic [NC-1:0]     core_we;
  logic [NC*AW-1:0]  core_addr;
  logic [NC*AW-1:0]  core_wdata;
  logic [NC-1:0]     core_ack;
  logic [AW-1:0]     core_rdata;
  logic              mem_read;
  logic              mem_write;
  logic              sharedAccess;
  logic [AW-1:0]     address;
  logic [AW-1:0]     data_in;
  logic [AW-1:0]     data_out;
`ifdef SHARED_ARB_STATS_EN
  logic [NC*16-1:0]  grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  logic        mem_loaded = 1'b0;

  shared_mem_arbiter #(
    .N_CORES (NC),
    .ADDR_W  (AW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_ack     (core_ack),
    .core_rdata   (core_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .sharedAccess (sharedAccess),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
`ifdef SHARED_ARB_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: loads 100+i on the first edge, then commits writes.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(100 + i);
      mem_loaded <= 1'b1;
    end else if (sharedAccess && mem_write) begin
      mem[address[7:2]] <= data_in;
    end
  end

  always_comb data_out = mem[address[7:2]];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_core(input int k, input logic we, input logic [31:0] a,
                          input logic [31:0] d);
    core_we[k]             = we;
    core_addr[k*AW +: AW]  = a;
    core_wdata[k*AW +: AW] = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    core_req   = '0;
    core_we    = '0;
    core_addr  = '0;
    core_wdata = '0;
    reset_n    = 1'b0;
    tick();
    tick();
    checks++;
    if ({core_ack, mem_read, mem_write, sharedAccess} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got ack=%b rd=%b wr=%b sel=%b want all 0",
               core_ack, mem_read, mem_write, sharedAccess);
    end
    checks++;
    if (core_rdata !== 32'd0 || address !== 32'd0 || data_in !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h din=%h want 0", core_rdata,
               address, data_in);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    set_core(0, 1'b0, 32'd12, 32'd0);
    core_req = 4'b0001;
    tick();
    checks++;
    if (address !== 32'd12 || mem_read !== 1'b1 || sharedAccess !== 1'b1 ||
        mem_write !== 1'b0) begin
      errors++;
      $display("FAIL rd_access: got addr=%0d rd=%b wr=%b sel=%b want 12 1 0 1", address,
               mem_read, mem_write, sharedAccess);
    end
    tick();
    checks++;
    if (core_ack !== 4'b0001 || core_rdata !== 32'd103) begin
      errors++;
      $display("FAIL rd_ack: got ack=%b rdata=%0d want 0001 103", core_ack, core_rdata);
    end
    tick();
    checks++;
    if (sharedAccess !== 1'b0 || core_ack !== 4'b0000) begin
      errors++;
      $display("FAIL rd_no_double: got sel=%b ack=%b want 0 0000", sharedAccess, core_ack);
    end
    core_req = 4'b0000;
  endtask

  task automatic test_write_read();
    set_core(1, 1'b1, 32'd28, 32'hDEADBEEF);
    core_req = 4'b0010;
    tick();
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || address !== 32'd28 ||
        data_in !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_access: got wr=%b rd=%b addr=%0d din=%h want 1 0 28 deadbeef",
               mem_write, mem_read, address, data_in);
    end
    tick();
    checks++;
    if (core_ack !== 4'b0010 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack: got ack=%b wr=%b want 0010 0", core_ack, mem_write);
    end
    checks++;
    if (core_rdata !== 32'd103) begin
      errors++;
      $display("FAIL wr_rdata_hold: got %0d want 103", core_rdata);
    end
    tick();
    checks++;
    if (sharedAccess !== 1'b0) begin
      errors++;
      $display("FAIL wr_no_double: got sel=%b want 0", sharedAccess);
    end
    set_core(1, 1'b0, 32'd28, 32'd0);
    tick();
    checks++;
    if (mem_read !== 1'b1 || address !== 32'd28) begin
      errors++;
      $display("FAIL rb_access: got rd=%b addr=%0d want 1 28", mem_read, address);
    end
    tick();
    checks++;
    if (core_ack !== 4'b0010 || core_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rb_ack: got ack=%b rdata=%h want 0010 deadbeef", core_ack, core_rdata);
    end
    tick();
    core_req = 4'b0000;
  endtask

  task automatic test_all_four();
    do_reset();
    for (int k = 0; k < 4; k++) set_core(k, 1'b0, 32'(4 * k), 32'd0);
    core_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k > 0) core_req[k-1] = 1'b0;
      checks++;
      if (sharedAccess !== 1'b1 || address !== 32'(4 * k)) begin
        errors++;
        $display("FAIL all4_grant%0d: got sel=%b addr=%0d want 1 %0d", k, sharedAccess,
                 address, 4 * k);
      end
      tick();
      checks++;
      if (core_ack !== 4'(1 << k) || core_rdata !== 32'(100 + k)) begin
        errors++;
        $display("FAIL all4_ack%0d: got ack=%b rdata=%0d want %b %0d", k, core_ack,
                 core_rdata, 4'(1 << k), 100 + k);
      end
    end
    tick();
    core_req[3] = 1'b0;
    checks++;
    if (sharedAccess !== 1'b0) begin
      errors++;
      $display("FAIL all4_idle: got sel=%b want 0", sharedAccess);
    end
    checks++;
    if (dut.ptr_q !== 2'd0) begin
      errors++;
      $display("FAIL all4_ptr: got %0d want 0", dut.ptr_q);
    end
`ifdef SHARED_ARB_STATS_EN
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (grant_cnt[k*16 +: 16] !== 16'd1) begin
        errors++;
        $display("FAIL stats_cnt%0d: got %0d want 1", k, grant_cnt[k*16 +: 16]);
      end
    end
`endif
  endtask

  task automatic test_fairness();
    set_core(0, 1'b0, 32'd16, 32'd0);
    set_core(2, 1'b0, 32'd32, 32'd0);
    core_req = 4'b0001;
    tick();
    checks++;
    if (address !== 32'd16 || sharedAccess !== 1'b1) begin
      errors++;
      $display("FAIL fair_c0_first: got addr=%0d sel=%b want 16 1", address, sharedAccess);
    end
    core_req[2] = 1'b1;
    tick();
    checks++;
    if (core_ack !== 4'b0001 || core_rdata !== 32'd104) begin
      errors++;
      $display("FAIL fair_c0_ack: got ack=%b rdata=%0d want 0001 104", core_ack, core_rdata);
    end
    tick();
    checks++;
    if (address !== 32'd32 || sharedAccess !== 1'b1) begin
      errors++;
      $display("FAIL fair_c2_grant: got addr=%0d sel=%b want 32 1", address, sharedAccess);
    end
    tick();
    checks++;
    if (core_ack !== 4'b0100 || core_rdata !== 32'd108) begin
      errors++;
      $display("FAIL fair_c2_ack: got ack=%b rdata=%0d want 0100 108", core_ack, core_rdata);
    end
    tick();
    core_req[2] = 1'b0;
    checks++;
    if (address !== 32'd16 || sharedAccess !== 1'b1) begin
      errors++;
      $display("FAIL fair_c0_again: got addr=%0d sel=%b want 16 1", address, sharedAccess);
    end
    tick();
    checks++;
    if (core_ack !== 4'b0001) begin
      errors++;
      $display("FAIL fair_c0_ack2: got ack=%b want 0001", core_ack);
    end
    tick();
    core_req = 4'b0000;
  endtask

  task automatic test_reset_in_access();
    set_core(3, 1'b1, 32'd20, 32'd77);
    core_req = 4'b1000;
    tick();
    checks++;
    if (mem_write !== 1'b1 || address !== 32'd20) begin
      errors++;
      $display("FAIL rst_pre: got wr=%b addr=%0d want 1 20", mem_write, address);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, sharedAccess} !== 3'b000) begin
      errors++;
      $display("FAIL rst_strobes: got rd=%b wr=%b sel=%b want 0 0 0", mem_read, mem_write,
               sharedAccess);
    end
    core_req = 4'b0000;
    set_core(3, 1'b0, 32'd20, 32'd0);
    tick();
    checks++;
    if (core_ack !== 4'b0000 || dut.ptr_q !== 2'd0) begin
      errors++;
      $display("FAIL rst_no_ack: got ack=%b ptr=%0d want 0000 0", core_ack, dut.ptr_q);
    end
    reset_n = 1'b1;
    tick();
    core_req = 4'b1000;
    tick();
    checks++;
    if (mem_read !== 1'b1 || address !== 32'd20) begin
      errors++;
      $display("FAIL rst_rb_access: got rd=%b addr=%0d want 1 20", mem_read, address);
    end
    tick();
    checks++;
    if (core_ack !== 4'b1000 || core_rdata !== 32'd105) begin
      errors++;
      $display("FAIL rst_rb_data: got ack=%b rdata=%0d want 1000 105", core_ack, core_rdata);
    end
    tick();
    core_req = 4'b0000;
  endtask

`ifdef SHARED_ARB_STATS_EN
  task automatic test_stats_saturate();
    dut.cnt_q[1] = 16'hFFFF;
    set_core(1, 1'b0, 32'd4, 32'd0);
    core_req = 4'b0010;
    tick();
    tick();
    checks++;
    if (core_ack !== 4'b0010 || grant_cnt[16 +: 16] !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_sat: got ack=%b cnt1=%h want 0010 ffff", core_ack,
               grant_cnt[16 +: 16]);
    end
    checks++;
    if (grant_cnt[48 +: 16] !== 16'd1) begin
      errors++;
      $display("FAIL stats_cnt3: got %0d want 1", grant_cnt[48 +: 16]);
    end
    tick();
    core_req = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_all_four();
    test_fairness();
    test_reset_in_access();
`ifdef SHARED_ARB_STATS_EN
    test_stats_saturate();
`endif
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
